// File: rtl/imem_pkg.sv
// Shared constants, load-state encoding and address helper for the instruction-memory loader.
package imem_pkg;

  localparam int unsigned IM_SIZE_DEFAULT = 32'd128;
  localparam logic [5:0]  HALT_OPCODE     = 6'b111111;
  localparam logic [31:0] IM_HALT_WORD    = {HALT_OPCODE, 26'd0};
  // The CPU pre-increments its PC, so fetch begins at address 0 after the run pulse.
  localparam logic [31:0] PC_INIT         = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PAD  = 2'd2,
    DONE = 2'd3
  } load_state_e;

  function automatic logic [31:0] word_addr(input logic [29:0] index);
    return {index, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
interface imem_loader_if;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_waddr;
  logic [31:0] im_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, im_we, im_waddr, im_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, im_we, im_waddr, im_wdata
  );

endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Packs accepted bytes MSB-first into 32-bit words; flags the word on its 4th byte.
module byte_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [23:0] hold;
  logic [1:0]  count;

  // Holding register and mod-4 byte counter; a partial word waits here indefinitely.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      hold  <= 24'd0;
      count <= 2'd0;
    end else if (accept) begin
      hold  <= {hold[15:0], data};
      count <= count + 2'd1;
    end
  end

  assign word_valid = accept && (count == 2'd3);
  assign word_data  = {hold, data};

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: byte stream in, sequential word writes out, CPU held until done.
// Optional halt-word fill of the remaining memory is enabled by defining IMEM_LOADER_PAD_EN.
module imem_loader #(
  parameter int unsigned SIZE_IM   = imem_pkg::IM_SIZE_DEFAULT,
  parameter logic [31:0] HALT_WORD = imem_pkg::IM_HALT_WORD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  imem_loader_if.master            bus,
  output logic [$clog2(SIZE_IM):0] word_count,
  output logic                     busy,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     run_pulse
);

  import imem_pkg::*;

  localparam int WC = $clog2(SIZE_IM) + 1;
  localparam logic [WC-1:0] SIZE_W   = WC'(SIZE_IM);
  localparam logic [WC-1:0] LAST_IDX = WC'(SIZE_IM - 1);
`ifdef IMEM_LOADER_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  load_state_e   state;
  logic [WC-1:0] index;
  logic [WC-1:0] count;
  logic          ending;
  logic          pad_next;
  logic          we;
  logic [31:0]   waddr;
  logic [31:0]   wdata;
  logic          busy_q;
  logic          done_q;
  logic          pulse_q;

  logic          in_ready;
  logic          accept;
  logic          load_entry;
  logic          word_valid;
  logic [31:0]   word_data;
  logic          is_halt;
  logic          is_last;

  // ending marks the cycle the final stream word is being written: no more bytes taken.
  assign in_ready   = (state == LOAD) && !ending;
  assign accept     = bus.in_valid && in_ready;
  assign load_entry = start && ((state == IDLE) || (state == DONE));
  assign is_halt    = (word_data == HALT_WORD);
  assign is_last    = (index == LAST_IDX);

  byte_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (load_entry),
    .accept     (accept),
    .data       (bus.in_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  // Load sequencer with registered write port and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      index    <= '0;
      count    <= '0;
      ending   <= 1'b0;
      pad_next <= 1'b0;
      we       <= 1'b0;
      waddr    <= 32'd0;
      wdata    <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      we      <= 1'b0;
      pulse_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= LOAD;
            index    <= '0;
            count    <= '0;
            ending   <= 1'b0;
            pad_next <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        LOAD: begin
          if (ending) begin
            ending <= 1'b0;
            if (pad_next) begin
              // First fill write issues here so the fill stream has no bubble.
              state <= PAD;
              we    <= 1'b1;
              wdata <= HALT_WORD;
              waddr <= word_addr(30'(index));
              index <= index + WC'(1);
            end else begin
              state   <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pulse_q <= 1'b1;
            end
          end else if (word_valid) begin
            we    <= 1'b1;
            wdata <= word_data;
            waddr <= word_addr(30'(index));
            index <= index + WC'(1);
            count <= count + WC'(1);
            if (is_halt || is_last) begin
              ending   <= 1'b1;
              pad_next <= PAD_EN && is_halt && !is_last;
            end
          end
        end
`ifdef IMEM_LOADER_PAD_EN
        PAD: begin
          if (index == SIZE_W) begin
            state   <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pulse_q <= 1'b1;
          end else begin
            we    <= 1'b1;
            wdata <= HALT_WORD;
            waddr <= word_addr(30'(index));
            index <= index + WC'(1);
          end
        end
`endif
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.im_we    = we;
  assign bus.im_waddr = waddr;
  assign bus.im_wdata = wdata;
  assign word_count   = count;
  assign busy         = busy_q;
  assign cpu_hold     = busy_q;
  assign done         = done_q;
  assign run_pulse    = pulse_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a word-level reference model.
`timescale 1ns/1ps
module tb_imem_loader;

`ifdef IMEM_LOADER_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam logic [31:0] HALT = 32'hFC00_0000;

  logic clk = 1'b0;
  logic rst_n;
  logic sel, v, st;
  logic [7:0] d;

  always #5 clk = ~clk;

  imem_loader_if ifa();
  imem_loader_if ifb();

  logic [7:0] wc_a;
  logic [2:0] wc_b;
  logic busy_a, hold_a, done_a, pulse_a;
  logic busy_b, hold_b, done_b, pulse_b;

  assign ifa.in_valid = v & ~sel;
  assign ifb.in_valid = v & sel;
  assign ifa.in_data  = d;
  assign ifb.in_data  = d;

  imem_loader #(.SIZE_IM(128)) dut (
    .clk(clk), .rst_n(rst_n), .start(st & ~sel), .bus(ifa), .word_count(wc_a),
    .busy(busy_a), .cpu_hold(hold_a), .done(done_a), .run_pulse(pulse_a)
  );

  imem_loader #(.SIZE_IM(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(st & sel), .bus(ifb), .word_count(wc_b),
    .busy(busy_b), .cpu_hold(hold_b), .done(done_b), .run_pulse(pulse_b)
  );

  logic rdy, we_m, busy_m, hold_m, done_m, pulse_m;
  logic [31:0] waddr_m, wdata_m;
  logic [7:0] wc_m;
  assign rdy     = sel ? ifb.in_ready : ifa.in_ready;
  assign we_m    = sel ? ifb.im_we    : ifa.im_we;
  assign waddr_m = sel ? ifb.im_waddr : ifa.im_waddr;
  assign wdata_m = sel ? ifb.im_wdata : ifa.im_wdata;
  assign wc_m    = sel ? {5'd0, wc_b} : wc_a;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign hold_m  = sel ? hold_b  : hold_a;
  assign done_m  = sel ? done_b  : done_a;
  assign pulse_m = sel ? pulse_b : pulse_a;

  // Observation log, sampled on the falling edge.
  int cyc = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int wr_cyc[$];
  int hs_cyc[$];
  int done_cyc[$];
  int pulses = 0;
  int we_in_done = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v && rdy) hs_cyc.push_back(cyc);
    if (we_m) begin
      wr_addr.push_back(waddr_m);
      wr_data.push_back(wdata_m);
      wr_cyc.push_back(cyc);
      if (done_m) we_in_done <= we_in_done + 1;
    end
    if (pulse_m) pulses <= pulses + 1;
    if (done_m && !done_prev) done_cyc.push_back(cyc);
    done_prev <= done_m;
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: words from the byte stream, stop on halt or full memory, optional fill.
  logic [7:0]  stream[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int exp_nw, exp_acc;

  task automatic model(input int size);
    logic [31:0] w;
    bit halted;
    exp_addr.delete();
    exp_data.delete();
    exp_nw = 0;
    halted = 1'b0;
    for (int i = 0; i + 3 < stream.size() && !halted && exp_nw < size; i += 4) begin
      w = {stream[i], stream[i+1], stream[i+2], stream[i+3]};
      exp_addr.push_back(32'(exp_nw * 4));
      exp_data.push_back(w);
      exp_nw++;
      if (w == HALT) halted = 1'b1;
    end
    exp_acc = (halted || exp_nw == size) ? exp_nw * 4 : stream.size();
    if (PAD && halted)
      for (int a = exp_nw; a < size; a++) begin
        exp_addr.push_back(32'(a * 4));
        exp_data.push_back(HALT);
      end
  endtask

  task automatic push_word(input logic [31:0] w);
    stream.push_back(w[31:24]);
    stream.push_back(w[23:16]);
    stream.push_back(w[15:8]);
    stream.push_back(w[7:0]);
  endtask

  function automatic logic [31:0] rand_word();
    return {8'($urandom_range(0, 251)), 24'($urandom)};
  endfunction

  task automatic load_prog();
    stream.delete();
    push_word(32'h2008_0005);
    push_word(32'h2009_0007);
    push_word(32'h0109_5020);
    push_word(HALT);
  endtask

  task automatic send_byte(input logic [7:0] b, output bit got);
    got = 1'b0;
    v = 1'b1;
    d = b;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rdy) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    if (!got) v = 1'b0;
  endtask

  task automatic pulse_start();
    st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_flags"}, {58'd0, rdy, we_m, busy_m, hold_m, done_m, pulse_m}, 64'd0);
    check_eq({tag, "_waddr"}, 64'(waddr_m), 64'd0);
    check_eq({tag, "_wdata"}, 64'(wdata_m), 64'd0);
    check_eq({tag, "_wc"}, 64'(wc_m), 64'd0);
  endtask

  // gap: 0 continuous, 1 one idle cycle per byte, 2 random idles; mid: byte index for a stray start.
  task automatic run(input string tag, input bit s, input int gap, input int mid);
    int wb, hb, pb, db, dcb, n_wr, n_hs;
    bit got;
    model(s ? 4 : 128);
    sel = s;
    @(posedge clk); #1;
    wb = wr_addr.size(); hb = hs_cyc.size(); pb = pulses; db = we_in_done; dcb = done_cyc.size();
    pulse_start();
    check_eq({tag, "_wc_cleared"}, 64'(wc_m), 64'd0);
    check_eq({tag, "_busy"}, {62'd0, busy_m, hold_m}, 64'd3);
    for (int i = 0; i < stream.size(); i++) begin
      if (i == mid) begin
        v = 1'b0;
        pulse_start();
      end
      if (gap == 1) begin
        v = 1'b0;
        @(posedge clk); #1;
      end else if (gap == 2) begin
        v = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      send_byte(stream[i], got);
    end
    v = 1'b0;
    for (int k = 0; k < 600 && !done_m; k++) @(negedge clk);
    check_eq({tag, "_done"}, 64'(done_m), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    n_wr = wr_addr.size() - wb;
    n_hs = hs_cyc.size() - hb;
    check_eq({tag, "_nwrites"}, 64'(n_wr), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < n_wr; i++)
      check_eq({tag, "_write"}, {wr_addr[wb+i], wr_data[wb+i]}, {exp_addr[i], exp_data[i]});
    for (int i = 0; i < exp_nw && i < n_wr && 4*i+3 < n_hs; i++)
      check_eq({tag, "_latency"}, 64'(wr_cyc[wb+i]), 64'(hs_cyc[hb+4*i+3] + 1));
    check_eq({tag, "_accepted"}, 64'(n_hs), 64'(exp_acc));
    check_eq({tag, "_word_count"}, 64'(wc_m), 64'(exp_nw));
    check_eq({tag, "_pulses"}, 64'(pulses - pb), 64'd1);
    check_eq({tag, "_we_in_done"}, 64'(we_in_done - db), 64'd0);
    check_eq({tag, "_released"}, {62'd0, busy_m, hold_m}, 64'd0);
    if (n_wr > 0 && done_cyc.size() > dcb)
      check_eq({tag, "_done_time"}, 64'(done_cyc[dcb]), 64'(wr_cyc[wb+n_wr-1] + 1));
    else
      check_eq({tag, "_done_seen"}, 64'(done_cyc.size() - dcb), 64'd1);
  endtask

  initial begin
    int wb;
    bit got;
    int n, p;
    rst_n = 1'b0; sel = 1'b0; v = 1'b0; st = 1'b0; d = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;

    load_prog();
    run("prog", 1'b0, 0, -1);
    run("prog_gaps", 1'b0, 1, -1);

    stream.delete();
    for (int i = 0; i < 5; i++) push_word(rand_word());
    run("capacity", 1'b1, 2, -1);

    // Reset after two bytes of the first word.
    load_prog();
    sel = 1'b0;
    @(posedge clk); #1;
    wb = wr_addr.size();
    pulse_start();
    send_byte(stream[0], got);
    send_byte(stream[1], got);
    v = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("mid_reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("mid_reset_nowrite", 64'(wr_addr.size() - wb), 64'd0);
    run("after_reset", 1'b0, 0, -1);

    run("start_in_load", 1'b0, 0, 5);
    stream.delete();
    push_word(rand_word());
    push_word(rand_word());
    push_word(HALT);
    run("reload_two_words", 1'b0, 2, -1);

    for (int r = 0; r < 4; r++) begin
      stream.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) push_word(rand_word());
      push_word(HALT);
      for (int i = 0; i < 3; i++) stream.push_back(8'($urandom));
      run("rand_big", 1'b0, 2, -1);
    end

    for (int r = 0; r < 4; r++) begin
      stream.delete();
      n = $urandom_range(4, 6);
      p = (r == 0) ? 3 : $urandom_range(0, 5);
      for (int i = 0; i < n; i++) push_word((i == p) ? HALT : rand_word());
      run("rand_small", 1'b1, 2, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
